// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
// I2S transmitter: two 8-bit AXI-stream channels sent MSB first with one-bit delay
// in 16-bit slots; SCK and LRCLK are derived from sys_clk by a half-period divider.
module i2s_tx #(
  parameter int SCK_HALF = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] s_axis_tdata_l,
  input  logic       s_axis_tvalid_l,
  output logic       s_axis_tready_l,
  input  logic [7:0] s_axis_tdata_r,
  input  logic       s_axis_tvalid_r,
  output logic       s_axis_tready_r,
  output logic       SCK,
  output logic       LRCLK,
  output logic       SDATA,
  output logic       underrun_l,
  output logic       underrun_r
);
  localparam int DIV_W = $clog2(SCK_HALF);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [DIV_W-1:0] div_reg;
  logic             sck_reg;
  logic             lrclk_reg;
  logic             sdata_reg;
  logic [4:0]       bit_cnt_reg;

  logic [1:0] tvalid;
  logic [1:0] tready;
  logic [1:0] xfer;
  logic [1:0] shift_en;
  logic [7:0] tdata     [2];
  logic [7:0] hold_reg  [2];
  logic [7:0] shift_reg [2];
  logic       full_reg  [2];
  logic       underrun_reg [2];

  logic       wrap;
  logic       fall_evt;
  logic       frame_edge;
  logic       load;
  logic       stop;
  logic [4:0] bit_next;
  logic       slot_l;
  logic       slot_r;
  logic       sdata_next;

  assign tdata[0]  = s_axis_tdata_l;
  assign tdata[1]  = s_axis_tdata_r;
  assign tvalid[0] = s_axis_tvalid_l;
  assign tvalid[1] = s_axis_tvalid_r;

  assign wrap       = (div_reg == DIV_W'(SCK_HALF - 1));
  assign fall_evt   = (state_reg == RUN) && wrap && sck_reg;
  assign bit_next   = bit_cnt_reg + 5'd1;
  assign frame_edge = fall_evt && (bit_next == 5'd0);
  assign load       = frame_edge && enable;
  assign stop       = frame_edge && !enable;

  // Data bits occupy n=1..8 (left) and n=17..24 (right); the rest is padding.
  assign slot_l     = (bit_next >= 5'd1)  && (bit_next <= 5'd8);
  assign slot_r     = (bit_next >= 5'd17) && (bit_next <= 5'd24);
  assign shift_en   = {fall_evt && slot_r, fall_evt && slot_l};
  assign sdata_next = slot_l ? shift_reg[0][7] : (slot_r ? shift_reg[1][7] : 1'b0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign tready[gi] = ~full_reg[gi] & ~rst;
    assign xfer[gi]   = tvalid[gi] & tready[gi];

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        full_reg[gi]     <= 1'b0;
        hold_reg[gi]     <= 8'h00;
        shift_reg[gi]    <= 8'h00;
        underrun_reg[gi] <= 1'b0;
      end else begin
        underrun_reg[gi] <= 1'b0;
        if (load) begin
          if (full_reg[gi]) begin
            shift_reg[gi] <= hold_reg[gi];
            full_reg[gi]  <= 1'b0;
          end else begin
            shift_reg[gi]    <= 8'h00;
            underrun_reg[gi] <= 1'b1;
          end
        end else if (shift_en[gi]) begin
          shift_reg[gi] <= {shift_reg[gi][6:0], 1'b0};
        end
        // A transfer on an empty channel's load edge lands in holding for the next frame.
        if (xfer[gi]) begin
          hold_reg[gi] <= tdata[gi];
          full_reg[gi] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      sck_reg     <= 1'b0;
      lrclk_reg   <= 1'b1;
      sdata_reg   <= 1'b0;
      bit_cnt_reg <= 5'd31;
    end else if (state_reg == IDLE) begin
      if (enable) begin
        state_reg   <= RUN;
        div_reg     <= '0;
        sck_reg     <= 1'b0;
        bit_cnt_reg <= 5'd31;
      end
    end else begin
      if (wrap) begin
        div_reg <= '0;
        sck_reg <= ~sck_reg;
        if (sck_reg) begin
          if (stop) begin
            state_reg <= IDLE;
            sck_reg   <= 1'b0;
            lrclk_reg <= 1'b1;
            sdata_reg <= 1'b0;
          end else begin
            bit_cnt_reg <= bit_next;
            lrclk_reg   <= bit_next[4];
            sdata_reg   <= sdata_next;
          end
        end
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  assign s_axis_tready_l = tready[0];
  assign s_axis_tready_r = tready[1];
  assign SCK             = sck_reg;
  assign LRCLK           = lrclk_reg;
  assign SDATA           = sdata_reg;
  assign underrun_l      = underrun_reg[0];
  assign underrun_r      = underrun_reg[1];
endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
// Directed bench for i2s_tx: expected frames are queued as stimulus is applied and
// checked against frames decoded from SCK/LRCLK/SDATA by a receiver-style monitor.
module tb_i2s_tx;
  localparam int SCK_HALF = 4;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] tdata_l = 8'h00;
  logic       tvalid_l = 1'b0;
  logic       tready_l;
  logic [7:0] tdata_r = 8'h00;
  logic       tvalid_r = 1'b0;
  logic       tready_r;
  logic       sck;
  logic       lrclk;
  logic       sdata;
  logic       ur_l;
  logic       ur_r;

  i2s_tx #(.SCK_HALF(SCK_HALF)) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .enable          (enable),
    .s_axis_tdata_l  (tdata_l),
    .s_axis_tvalid_l (tvalid_l),
    .s_axis_tready_l (tready_l),
    .s_axis_tdata_r  (tdata_r),
    .s_axis_tvalid_r (tvalid_r),
    .s_axis_tready_r (tready_r),
    .SCK             (sck),
    .LRCLK           (lrclk),
    .SDATA           (sdata),
    .underrun_l      (ur_l),
    .underrun_r      (ur_r)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] l;
    logic [7:0] r;
    logic       ul;
    logic       ur;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int frames_started = 0;
  int frames_done = 0;
  int mon_idx = 0;
  bit mon_in = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] l, input logic [7:0] r,
                                input logic ul, input logic ur);
    frame_t f;
    f.l = l; f.r = r; f.ul = ul; f.ur = ur;
    return f;
  endfunction

  // Receiver: samples on SCK rising edges, frames start where LRCLK falls.
  initial begin : monitor
    logic        prev_sck;
    logic        prev_lr;
    logic [31:0] bits;
    logic [7:0]  got_l;
    logic [7:0]  got_r;
    int          since;
    bit          gap_ok;
    bit          fmt_ok;
    int          pend_l, pend_r, fr_l, fr_r;
    frame_t      e;
    prev_sck = 1'b0; prev_lr = 1'b1; bits = '0; since = 0; gap_ok = 1'b0;
    fmt_ok = 1'b1; pend_l = 0; pend_r = 0; fr_l = 0; fr_r = 0;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        mon_in = 1'b0; prev_sck = sck; prev_lr = 1'b1; gap_ok = 1'b0;
        since = 0; pend_l = 0; pend_r = 0;
      end else begin
        since++;
        pend_l += int'(ur_l);
        pend_r += int'(ur_r);
        if (sck !== prev_sck) begin
          if (gap_ok) check("sck_half_period", 32'(since), SCK_HALF);
          gap_ok = 1'b1;
          since = 0;
          if (sck === 1'b1) begin
            if (lrclk === 1'b0 && prev_lr === 1'b1) begin
              mon_in = 1'b1; mon_idx = 0; bits = '0; fmt_ok = 1'b1;
              fr_l = pend_l; fr_r = pend_r; pend_l = 0; pend_r = 0;
              frames_started++;
            end else if (mon_in) begin
              mon_idx++;
            end
            if (mon_in) begin
              bits[mon_idx] = sdata;
              if (lrclk !== (mon_idx >= 16)) fmt_ok = 1'b0;
            end
            prev_lr = lrclk;
            if (mon_in && mon_idx == 31) begin
              mon_in = 1'b0;
              frames_done++;
              for (int k = 0; k < 8; k++) begin
                got_l[7-k] = bits[1+k];
                got_r[7-k] = bits[17+k];
              end
              if ((bits & ~32'h01FE_01FE) != 32'h0) fmt_ok = 1'b0;
              $display("frame %0d L=%02h R=%02h underrun_l=%0d underrun_r=%0d",
                       frames_done, got_l, got_r, fr_l, fr_r);
              check("frame_expected", 32'(exp_q.size() > 0), 1);
              if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("left_byte", 32'(got_l), 32'(e.l));
                check("right_byte", 32'(got_r), 32'(e.r));
                check("underrun_l_pulses", 32'(fr_l), 32'(e.ul));
                check("underrun_r_pulses", 32'(fr_r), 32'(e.ur));
                check("frame_format", 32'(fmt_ok), 1);
              end
            end
          end
        end else if (since > 4 * SCK_HALF) begin
          gap_ok = 1'b0;
        end
        prev_sck = sck;
      end
    end
  end

  task automatic wait_started(input int target);
    int t = 0;
    while (frames_started < target && t < 5000) begin
      @(negedge sys_clk);
      t++;
    end
    check("frame_start_timeout", 32'(frames_started >= target), 1);
  endtask

  task automatic wait_bit(input int n);
    int t = 0;
    while (!(mon_in && mon_idx == n) && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    check("bit_wait_timeout", 32'(mon_in && mon_idx == n), 1);
  endtask

  task automatic send(input bit ch, input logic [7:0] d);
    int t = 0;
    @(negedge sys_clk);
    if (ch == 1'b0) begin tdata_l = d; tvalid_l = 1'b1; end
    else            begin tdata_r = d; tvalid_r = 1'b1; end
    while (((ch == 1'b0) ? tready_l : tready_r) !== 1'b1 && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    check("send_ready", 32'((ch == 1'b0) ? tready_l : tready_r), 1);
    @(posedge sys_clk);
    #1;
    tvalid_l = 1'b0;
    tvalid_r = 1'b0;
    check("send_tready_drop", 32'((ch == 1'b0) ? tready_l : tready_r), 0);
    $display("accept ch=%0d data=%02h", ch, d);
  endtask

  task automatic finish_run(input int base_done, input int k);
    int t = 0;
    int changes = 0;
    logic p;
    while (frames_done < base_done + k && t < 5000) begin
      @(negedge sys_clk);
      t++;
    end
    check("frame_done_timeout", 32'(frames_done >= base_done + k), 1);
    repeat (SCK_HALF + 3) @(negedge sys_clk);
    check("idle_sck", 32'(sck), 0);
    check("idle_lrclk", 32'(lrclk), 1);
    check("idle_sdata", 32'(sdata), 0);
    p = sck;
    repeat (40) begin
      @(negedge sys_clk);
      if (sck !== p) changes++;
      p = sck;
    end
    check("idle_no_sck_edges", 32'(changes), 0);
  endtask

  task automatic run_frames(input int k);
    int bs = frames_started;
    int bd = frames_done;
    @(negedge sys_clk);
    enable = 1'b1;
    wait_started(bs + k);
    enable = 1'b0;
    finish_run(bd, k);
  endtask

  initial begin : stimulus
    int bs, bd;
    // Reset values
    @(negedge sys_clk);
    check("rst_sck", 32'(sck), 0);
    check("rst_lrclk", 32'(lrclk), 1);
    check("rst_sdata", 32'(sdata), 0);
    check("rst_tready_l", 32'(tready_l), 0);
    check("rst_tready_r", 32'(tready_r), 0);
    check("rst_underrun_l", 32'(ur_l), 0);
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    check("post_rst_tready_l", 32'(tready_l), 1);
    check("post_rst_tready_r", 32'(tready_r), 1);

    // Basic frame A5/3C, enable dropped at n=5
    send(1'b0, 8'hA5);
    send(1'b1, 8'h3C);
    exp_q.push_back(mk(8'hA5, 8'h3C, 1'b0, 1'b0));
    bd = frames_done;
    @(negedge sys_clk);
    enable = 1'b1;
    wait_bit(5);
    enable = 1'b0;
    finish_run(bd, 1);

    // No samples: zero frames with underruns
    repeat (3) exp_q.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1));
    run_frames(3);

    // Continuous left producer 0x01, 0x02, ...
    exp_q.push_back(mk(8'h01, 8'h00, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h02, 8'h00, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h03, 8'h00, 1'b0, 1'b1));
    fork
      begin : producer
        @(negedge sys_clk);
        tvalid_l = 1'b1;
        for (int i = 1; i <= 4; i++) begin
          int t = 0;
          tdata_l = 8'(i);
          while (tready_l !== 1'b1 && t < 3000) begin
            @(negedge sys_clk);
            t++;
          end
          check("prod_ready", 32'(tready_l), 1);
          @(posedge sys_clk);
          #1;
          check("prod_tready_drop", 32'(tready_l), 0);
          $display("accept ch=0 data=%02h", tdata_l);
        end
        tvalid_l = 1'b0;
      end
      run_frames(3);
    join

    // Reset mid-frame discards held samples (left still holds 0x04)
    send(1'b1, 8'h55);
    bs = frames_started;
    @(negedge sys_clk);
    enable = 1'b1;
    wait_started(bs + 1);
    send(1'b0, 8'h11);
    send(1'b1, 8'h22);
    wait_bit(20);
    #2;
    rst = 1'b1;
    #1;
    check("abort_sck", 32'(sck), 0);
    check("abort_lrclk", 32'(lrclk), 1);
    check("abort_sdata", 32'(sdata), 0);
    check("abort_tready_l", 32'(tready_l), 0);
    check("abort_tready_r", 32'(tready_r), 0);
    repeat (3) @(negedge sys_clk);
    exp_q.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1));
    bd = frames_done;
    bs = frames_started;
    rst = 1'b0;
    @(negedge sys_clk);
    check("release_tready_l", 32'(tready_l), 1);
    check("release_tready_r", 32'(tready_r), 1);
    wait_started(bs + 1);
    enable = 1'b0;
    finish_run(bd, 1);

    // Left transfer exactly on the frame-load edge
    send(1'b1, 8'h81);
    exp_q.push_back(mk(8'h00, 8'h81, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h7E, 8'h00, 1'b0, 1'b1));
    bs = frames_started;
    bd = frames_done;
    @(negedge sys_clk);
    enable = 1'b1;
    repeat (2 * SCK_HALF) @(negedge sys_clk);
    tdata_l = 8'h7E;
    tvalid_l = 1'b1;
    @(posedge sys_clk);
    #1;
    tvalid_l = 1'b0;
    check("edge_xfer_held", 32'(tready_l), 0);
    check("edge_underrun_pulse", 32'(ur_l), 1);
    wait_started(bs + 2);
    enable = 1'b0;
    finish_run(bd, 2);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
